// File: rtl/pipe_stage_buffer_pkg.sv
// pipe_stage_buffer_pkg: shared widths, buffer defaults and stage payload types
package pipe_stage_buffer_pkg;
    localparam int BIN_DIG = 32;
    localparam int PIPE_DEPTH_DEFAULT = 2;
    localparam int PIPE_CNT_W = 16;

    typedef logic [BIN_DIG-1:0] fetch_payload_t;

    typedef struct packed {
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [BIN_DIG-1:0] imm;
    } decode_payload_t;

    typedef struct packed {
        logic [4:0]         rd;
        logic               we;
        logic [BIN_DIG-1:0] result;
    } exec_payload_t;
endpackage

// File: rtl/pipe_stage_buffer_if.sv
// pipe_stage_buffer_if: valid/ready/data handshake between two pipeline stages
interface pipe_stage_buffer_if
    import pipe_stage_buffer_pkg::*;
#(
    parameter int DATA_W = BIN_DIG
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buffer_sat_counter.sv
// sat_counter: saturating accumulator with synchronous clear
module sat_counter #(
    parameter int W  = 16,
    parameter int IW = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [IW-1:0] inc_i,
    output logic [W-1:0]  cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(inc_i);
        cnt_d = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge CLK) cnt_q <= RST ? '0 : cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic valid/ready pipeline register with flush and stall/drop statistics
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int                DATA_W = BIN_DIG,
    parameter int                DEPTH  = PIPE_DEPTH_DEFAULT,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = PIPE_CNT_W
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush_i,
    pipe_stage_buffer_if.slave           in_i,
    pipe_stage_buffer_if.master          out_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic [CNT_W-1:0]             stall_cnt_o,
    output logic [CNT_W-1:0]             flush_drop_cnt_o
);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d, drop_inc;
    logic              push, pop, in_ready, out_valid, stall;

    // in_ready looks only at local state so no ready path chains across stages
    always_comb begin
        in_ready  = !RST && (count_q < OCC_W'(DEPTH));
        out_valid = count_q != '0;
        push      = in_i.valid && in_ready;
        pop       = out_valid && out_o.ready;
        wr_ptr_d  = !push ? wr_ptr_q : wr_ptr_q == PTR_W'(DEPTH-1) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d  = !pop ? rd_ptr_q : rd_ptr_q == PTR_W'(DEPTH-1) ? '0 : rd_ptr_q + 1'b1;
        count_d   = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
        stall     = out_valid && !out_o.ready && !flush_i;
        drop_inc  = flush_i ? count_q - OCC_W'(pop) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST || flush_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) if (push && !flush_i) mem_q[wr_ptr_q] <= in_i.data;

    assign in_i.ready  = in_ready;
    assign out_o.valid = out_valid;
    assign out_o.data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
    assign occupancy_o = count_q;

    sat_counter #(.W(CNT_W), .IW(1)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc_i (stall),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W), .IW(OCC_W)) u_drop_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc_i (drop_inc),
        .cnt_o (flush_drop_cnt_o)
    );
endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Generic, parametrised inter-stage pipeline register that replaces the fixed curr_*/next_* latches between fetch, decode, exec/dmem and writeback. It adds a valid/ready handshake, DEPTH-entry elastic buffering (skid), a synchronous flush for branch/exception kill, and per-stage stall/flush statistics. One instance is used per stage boundary, with DATA_W sized to the packed stage payload (e.g. instruction word, or opcode/rd/rs1/rs2/funct3/funct7/imm bundle).

Parameters:
DATA_W, BIN_DIG (32), payload width in bits; must be >= 1.
DEPTH, 2, number of buffer entries; must be >= 1; non-power-of-two allowed.
BUBBLE, '0 (DATA_W bits), value driven on out_data when the buffer is empty (NOP encoding).
CNT_W, 16, width of the statistics counters.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous, active-high reset.
flush  input  1  discard all buffered entries and any same-cycle push.
in_valid  input  1  upstream offers in_data.
in_ready  output  1  buffer can accept this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data holds a valid entry.
out_ready  input  1  downstream consumes this cycle.
out_data  output  DATA_W  oldest entry, or BUBBLE when empty.
occupancy  output  $clog2(DEPTH+1)  current number of valid entries.
stall_cnt  output  CNT_W  cycles with out_valid && !out_ready; saturating.
flush_drop_cnt  output  CNT_W  total entries discarded by flush; saturating.

Behaviour:
- Reset: RST is synchronous, active-high; clock is CLK. While RST is sampled high, all state clears on the edge. After reset: occupancy=0, out_valid=0, out_data=BUBBLE, stall_cnt=0, flush_drop_cnt=0. in_ready=0 while RST is high and 1 in the first cycle after.
- Storage: circular buffer mem[0..DEPTH-1] with wr_ptr, rd_ptr and count. Pointers wrap explicitly from DEPTH-1 to 0, not by bit truncation.
- push = in_valid && in_ready; pop = out_valid && out_ready; flush overrides both.
- in_ready = !RST && (count < DEPTH). It must not depend combinationally on out_ready, so there is no ready-to-ready path across stages.
- out_valid = (count != 0). out_data = mem[rd_ptr] when count != 0, else BUBBLE. First-word-fall-through.
- Latency: a push in cycle N is visible on out_data/out_valid in cycle N+1, never in cycle N.
- Push and pop together with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push when full: impossible because in_ready=0. Hence DEPTH=1 gives at most 1 transfer per 2 cycles under continuous flow; DEPTH>=2 sustains 1 transfer per cycle.
- Pop when empty: impossible because out_valid=0. out_ready is ignored.
- Flush (synchronous, highest priority after RST): next cycle count=0, wr_ptr=rd_ptr=0, out_valid=0. A same-cycle push is dropped and not counted. A same-cycle pop does not count as a drop. flush_drop_cnt += (count - pop), saturating.
- stall_cnt: +1 on every cycle with out_valid && !out_ready && !flush; saturates at 2^CNT_W-1 and does not wrap. Cleared only by RST.
- Holding data: while out_valid && !out_ready, out_data must remain stable.
- Mid-operation RST behaves like a flush, but also clears both counters and does not increment flush_drop_cnt.
- Data width: no arithmetic on the payload; bits are passed through unmodified.

Decomposition:
- Package defs (existing): keeps BIN_DIG. Add localparam-style constants PIPE_DEPTH_DEFAULT=2 and PIPE_CNT_W=16, plus a typedef for each stage payload (e.g. fetch_payload_t, decode_payload_t as packed structs) so DATA_W = $bits(payload_t).
- Sub-module sat_counter (parameters W, incr width), instantiated twice: +1 for stall_cnt and +count for flush_drop_cnt. Each instance has saturating add and synchronous clear.
- Pointer/count logic stays inline.

Test Plan:
1. Reset then idle: assert RST 2 cycles -> in_ready=0 during RST; then out_valid=0, out_data=BUBBLE(0), occupancy=0, in_ready=1, both counters 0.
2. Streaming, DEPTH=2, out_ready=1: push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 at cycles N+1..N+3, in_ready stays 1, stall_cnt=0.
3. Backpressure: out_ready=0, push 0xA0,0xA1,0xA2 -> third push refused (in_ready=0 at occupancy=2), out_data held 0xA0; after 5 blocked cycles stall_cnt=5; release out_ready -> 0xA0,0xA1 in order, then 0xA2 accepted.
4. Flush with full buffer plus same-cycle push and pop: occupancy=2, flush=1, in_valid=1 (0xFF), out_ready=1 -> next cycle occupancy=0, out_data=BUBBLE, flush_drop_cnt=1, and 0xFF never appears.
5. DEPTH=3 wrap: 10 push/pop pairs with values 1..10 -> output sequence 1..10 in order, pointers wrap at 2, no gaps or duplicates.
6. Saturation with CNT_W=4: hold stall 20 cycles -> stall_cnt=15 and stays at 15; RST clears it to 0.
